controle_multiciclo: RTL

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/riscv_pkg.sv | 78 +++++++
 rtl/controle_multiciclo_gerador_imediato.sv | 30 +++
 rtl/controle_multiciclo.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64I-subset definitions for the multicycle control: state codes, opcodes,
// write-back codes, and the instruction and immediate-format decoders.
`timescale 1ns/1ps
package riscv_pkg;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        ESPERA     = 3'd1,
        DECODIFICA = 3'd2,
        EXECUTA    = 3'd3,
        MEMORIA    = 3'd4,
        ESCRITA    = 3'd5,
        PARADO     = 3'd6
    } estado_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [3:0] {
        I_ILEGAL, I_LD, I_SD, I_ADD, I_SUB, I_ADDI,
        I_JAL, I_JALR, I_AUIPC, I_BEQ, I_ECALL
    } instr_t;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_U} fmt_t;

    // Classifies an instruction word; anything outside the supported subset is I_ILEGAL.
    function automatic instr_t decodifica(input logic [31:0] ir);
        instr_t     r;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        r  = I_ILEGAL;
        case (ir[6:0])
            OPC_LOAD:   if (f3 == 3'b011) r = I_LD;
            OPC_STORE:  if (f3 == 3'b011) r = I_SD;
            OPC_REG: begin
                if (f3 == 3'b000 && f7 == 7'b0000000)      r = I_ADD;
                else if (f3 == 3'b000 && f7 == 7'b0100000) r = I_SUB;
            end
            OPC_IMM:    if (f3 == 3'b000) r = I_ADDI;
            OPC_JAL:    r = I_JAL;
            OPC_JALR:   if (f3 == 3'b000) r = I_JALR;
            OPC_AUIPC:  r = I_AUIPC;
            OPC_BRANCH: if (f3 == 3'b000) r = I_BEQ;
            OPC_SYSTEM: if (ir == INSTR_ECALL) r = I_ECALL;
            default:    r = I_ILEGAL;
        endcase
        return r;
    endfunction

    function automatic fmt_t formato(input logic [6:0] opc);
        fmt_t f;
        case (opc)
            OPC_STORE:  f = FMT_S;
            OPC_BRANCH: f = FMT_B;
            OPC_JAL:    f = FMT_J;
            OPC_AUIPC:  f = FMT_U;
            default:    f = FMT_I;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/controle_multiciclo_gerador_imediato.sv
// Immediate generator: extracts the I/S/B/J/U immediate from the IR and sign-extends it to XLEN.
`timescale 1ns/1ps
module gerador_imediato
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:7]     ir,
    input  fmt_t            formato,
    output logic [XLEN-1:0] imediato
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (formato)
            FMT_I:   imm32 = {{20{ir[31]}}, ir[31:20]};
            FMT_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_J:   imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            FMT_U:   imm32 = {ir[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed source, so the width cast sign-extends for XLEN=64.
    assign imediato = XLEN'(imm32);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control unit: fetch/wait/decode/execute/memory/write-back sequencing,
// PC update on each instruction's last cycle, and sticky halt/illegal stop state.
`timescale 1ns/1ps
module controle_multiciclo
    import riscv_pkg::*;
#(
    parameter int unsigned   XLEN     = 64,
    parameter int unsigned   PC_W     = 7,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_zero,
    output logic [PC_W-1:0] endr,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      ra,
    output logic [4:0]      rb,
    output logic [4:0]      rw,
    output logic            we_reg,
    output logic            we_mem,
    output logic            sel_a,
    output logic            sel_b,
    output logic            soma_ou_subtrai,
    output logic            subtraindo,
    output logic [1:0]      sel_wb,
    output logic [XLEN-1:0] imediato,
    output logic [2:0]      estado,
    output logic            halt,
    output logic            illegal
);

    estado_t     estado_q;
    logic [31:0] ir;
    logic        we_reg_q;
    logic        we_mem_q;
    instr_t      op;

    logic        ula_sel_a;
    logic        ula_sel_b;
    logic        ula_sub;
    logic [1:0]  wb_cod;
    logic        mantem_ula;

    logic [XLEN-1:0] pc_mais4;
    logic [XLEN-1:0] pc_desvio;
    logic [XLEN-1:0] pc_jalr;

    assign op = decodifica(ir);

    gerador_imediato #(.XLEN(XLEN)) u_imm (
        .ir       (ir[31:7]),
        .formato  (formato(ir[6:0])),
        .imediato (imediato)
    );

    assign ra     = ir[19:15];
    assign rb     = ir[24:20];
    assign rw     = ir[11:7];
    assign estado = estado_q;
    assign endr   = pc[PC_W+1:2];

    // Write enables are forced low while rst is high so an aborted instruction never writes.
    assign we_reg = we_reg_q & ~rst;
    assign we_mem = we_mem_q & ~rst;

    assign pc_mais4  = pc + XLEN'(4);
    assign pc_desvio = pc + imediato;
    assign pc_jalr   = alu_res & ~XLEN'(1);

    // ALU operand/operation and write-back source per instruction class.
    always_comb begin
        ula_sel_a = 1'b0;
        ula_sel_b = 1'b0;
        ula_sub   = 1'b0;
        wb_cod    = WB_ALU;
        case (op)
            I_LD, I_SD, I_ADDI, I_JALR: ula_sel_b = 1'b1;
            I_SUB, I_BEQ:               ula_sub   = 1'b1;
            I_AUIPC, I_JAL: begin
                ula_sel_a = 1'b1;
                ula_sel_b = 1'b1;
            end
            default: ;
        endcase
        case (op)
            I_LD:          wb_cod = WB_MEM;
            I_JAL, I_JALR: wb_cod = WB_PC4;
            default:       wb_cod = WB_ALU;
        endcase
    end

    // ALU selects stay stable from EXECUTA until the instruction's last cycle.
    always_comb begin
        mantem_ula = 1'b0;
        case (estado_q)
            DECODIFICA: mantem_ula = (op != I_ILEGAL) && (op != I_ECALL);
            EXECUTA:    mantem_ula = (op != I_BEQ);
            MEMORIA:    mantem_ula = (op == I_LD);
            default:    mantem_ula = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q        <= BUSCA;
            pc              <= PC_RESET;
            ir              <= INSTR_NOP;
            halt            <= 1'b0;
            illegal         <= 1'b0;
            we_reg_q        <= 1'b0;
            we_mem_q        <= 1'b0;
            sel_a           <= 1'b0;
            sel_b           <= 1'b0;
            soma_ou_subtrai <= 1'b0;
            subtraindo      <= 1'b0;
            sel_wb          <= WB_ALU;
        end else begin
            we_reg_q        <= 1'b0;
            we_mem_q        <= 1'b0;
            sel_wb          <= WB_ALU;
            sel_a           <= mantem_ula & ula_sel_a;
            sel_b           <= mantem_ula & ula_sel_b;
            soma_ou_subtrai <= mantem_ula;
            subtraindo      <= mantem_ula & ula_sub;
            case (estado_q)
                BUSCA:  estado_q <= ESPERA;
                ESPERA: begin
                    estado_q <= DECODIFICA;
                    ir       <= instr;
                end
                DECODIFICA: begin
                    if (op == I_ECALL) begin
                        estado_q <= PARADO;
                        halt     <= 1'b1;
                    end else if (op == I_ILEGAL) begin
                        estado_q <= PARADO;
                        halt     <= 1'b1;
                        illegal  <= 1'b1;
                    end else begin
                        estado_q <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    case (op)
                        I_BEQ: begin
                            estado_q <= BUSCA;
                            pc       <= alu_zero ? pc_desvio : pc_mais4;
                        end
                        I_LD, I_SD: begin
                            estado_q <= MEMORIA;
                            we_mem_q <= (op == I_SD);
                        end
                        default: begin
                            estado_q <= ESCRITA;
                            we_reg_q <= (rw != 5'd0);
                            sel_wb   <= wb_cod;
                        end
                    endcase
                end
                MEMORIA: begin
                    if (op == I_SD) begin
                        estado_q <= BUSCA;
                        pc       <= pc_mais4;
                    end else begin
                        estado_q <= ESCRITA;
                        we_reg_q <= (rw != 5'd0);
                        sel_wb   <= wb_cod;
                    end
                end
                ESCRITA: begin
                    estado_q <= BUSCA;
                    case (op)
                        I_JAL:   pc <= pc_desvio;
                        I_JALR:  pc <= pc_jalr;
                        default: pc <= pc_mais4;
                    endcase
                end
                default: estado_q <= PARADO;
            endcase
        end
    end

endmodule
